// File: rtl/canny_pkg.sv
// Shared types and window constants for the Canny pipeline control blocks.
package canny_pkg;

    // Per-stage shift mode issued by main_controller.
    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10,
        DOWN  = 2'b11
    } shift_mode_t;

    localparam int WIN9 = 9;
    localparam int WIN7 = 7;
    localparam int WIN5 = 5;
    localparam int WIN3 = 3;

endpackage

// File: rtl/fill_counter.sv
// Saturating fill counter: counts ticks up to N and then issues one
// registered done pulse. It stays quiet until cleared by a new frame.
module fill_counter #(
    parameter int N  = 9,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          tick,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          fired
);

    logic full;
    assign full = (count == CW'(N));

    // Count ticks, saturate at N, pulse done once on the cycle after saturation.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here samples pre-edge values.
        if (!n_rst || clear) begin
            count <= '0;
            done  <= 1'b0;
            fired <= 1'b0;
        end else begin
            done <= full && !fired;
            if (full) begin
                fired <= 1'b1;
            end
            if (tick && !full) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_position_tracker.sv
// Tracks the 9x9 Gaussian window over the image in a serpentine scan,
// issues one SRAM fetch per shifting cycle and returns the fill-done
// pulses and edge flags main_controller waits on.
// Optional: define SCAN_LINEAR_ADDR_EN to add a linear fetch_addr output
// built from a running row-base accumulator instead of a multiplier.
module scan_position_tracker
    import canny_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          enable9x9,
    input  logic          enable7x7,
    input  logic          enable5x5,
    input  logic          enable3x3,
    input  logic [1:0]    gaussian_buffer,
    input  logic [1:0]    gradient_buffer,
    input  logic [1:0]    suppression_buffer,
    input  logic [1:0]    hysteresis_buffer,
    output logic          gaussian_fill_done,
    output logic          gradient_fill_done,
    output logic          suppression_fill_done,
    output logic          hysteresis_fill_done,
    output logic          readx_up_max,
    output logic          readx_down_min,
    output logic          ready_max,
    output logic          fetch_valid,
    output logic          fetch_dir,
    output logic [XW-1:0] fetch_x,
    output logic [YW-1:0] fetch_y
`ifdef SCAN_LINEAR_ADDR_EN
    ,
    output logic [XW+YW-1:0] fetch_addr
`endif
);

    localparam int CW9 = $clog2(WIN9 + 1);
    localparam int CW7 = $clog2(WIN7 + 1);
    localparam int CW5 = $clog2(WIN5 + 1);
    localparam int CW3 = $clog2(WIN3 + 1);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - WIN9);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - WIN9);

    shift_mode_t g_mode;
    assign g_mode = shift_mode_t'(gaussian_buffer);

    logic [XW-1:0] wx, wx_n;
    logic [YW-1:0] wy, wy_n;
    logic          fill, fill_n;
    logic          fv_n, fd_n;
    logic [XW-1:0] fx_n;
    logic [YW-1:0] fy_n;

    logic [CW9-1:0] fc9_count;
    logic [CW7-1:0] fc7_count;
    logic [CW5-1:0] fc5_count;
    logic [CW3-1:0] fc3_count;
    logic           fc9_fired, fc7_fired, fc5_fired, fc3_fired;
    logic           tick9, tick7, tick5, tick3;

    // Lower stages only count once the stage above has announced its fill.
    assign tick9 = fill && enable9x9 && (g_mode == RIGHT);
    assign tick7 = fill && enable7x7 && (shift_mode_t'(gradient_buffer) == RIGHT) && fc9_fired;
    assign tick5 = fill && enable5x5 && (shift_mode_t'(suppression_buffer) == RIGHT) && fc7_fired;
    assign tick3 = fill && enable3x3 && (shift_mode_t'(hysteresis_buffer) == RIGHT) && fc5_fired;

    fill_counter #(.N(WIN9)) u_fc9 (
        .clk(clk), .n_rst(n_rst), .clear(start), .tick(tick9),
        .count(fc9_count), .done(gaussian_fill_done), .fired(fc9_fired)
    );
    fill_counter #(.N(WIN7)) u_fc7 (
        .clk(clk), .n_rst(n_rst), .clear(start), .tick(tick7),
        .count(fc7_count), .done(gradient_fill_done), .fired(fc7_fired)
    );
    fill_counter #(.N(WIN5)) u_fc5 (
        .clk(clk), .n_rst(n_rst), .clear(start), .tick(tick5),
        .count(fc5_count), .done(suppression_fill_done), .fired(fc5_fired)
    );
    fill_counter #(.N(WIN3)) u_fc3 (
        .clk(clk), .n_rst(n_rst), .clear(start), .tick(tick3),
        .count(fc3_count), .done(hysteresis_fill_done), .fired(fc3_fired)
    );

    // Only fc9 and fc3 counts feed logic here; the middle counts are internal.
    logic unused_counts;
    assign unused_counts = ^{fc7_count, fc5_count};

    // Fill ends on the same edge that raises hysteresis_fill_done.
    assign fill_n = fill && !((fc3_count == CW3'(WIN3)) && !fc3_fired);

    // Gaussian window step: next position and the fetch it implies.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        fv_n = 1'b0;
        fd_n = 1'b0;
        fx_n = '0;
        fy_n = '0;
        wx_n = wx;
        wy_n = wy;
        if (enable9x9) begin
            case (g_mode)
                RIGHT: begin
                    if (fill) begin
                        if (fc9_count != CW9'(WIN9)) begin
                            fv_n = 1'b1;
                            fx_n = XW'(fc9_count);
                            fy_n = wy;
                        end
                    end else if (wx < X_MAX) begin
                        fv_n = 1'b1;
                        fx_n = wx + XW'(WIN9);
                        fy_n = wy;
                        wx_n = wx + 1'b1;
                    end
                end
                LEFT: begin
                    if (wx != '0) begin
                        fv_n = 1'b1;
                        fx_n = wx - 1'b1;
                        fy_n = wy;
                        wx_n = wx - 1'b1;
                    end
                end
                DOWN: begin
                    if (wy < Y_MAX) begin
                        fv_n = 1'b1;
                        fd_n = 1'b1;
                        fx_n = wx;
                        fy_n = wy + YW'(WIN9);
                        wy_n = wy + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Position state plus registered fetch request and edge flags.
    always_ff @(posedge clk) begin
        if (!n_rst || start) begin
            wx             <= '0;
            wy             <= '0;
            fill           <= n_rst;
            fetch_valid    <= 1'b0;
            fetch_dir      <= 1'b0;
            fetch_x        <= '0;
            fetch_y        <= '0;
            readx_up_max   <= 1'b0;
            readx_down_min <= 1'b0;
            ready_max      <= 1'b0;
        end else begin
            wx             <= wx_n;
            wy             <= wy_n;
            fill           <= fill_n;
            fetch_valid    <= fv_n;
            fetch_dir      <= fd_n;
            fetch_x        <= fx_n;
            fetch_y        <= fy_n;
            readx_up_max   <= !fill_n && (wx_n == X_MAX);
            readx_down_min <= !fill_n && (wx_n == '0);
            ready_max      <= !fill_n && (wy_n == Y_MAX);
        end
    end

`ifdef SCAN_LINEAR_ADDR_EN
    localparam int AW = XW + YW;
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
    localparam logic [AW-1:0] ROW_NINE = AW'(WIN9 * IMG_W);

    logic [AW-1:0] row_base;
    logic [AW-1:0] addr_n;

    // Row fetches land nine rows below the window top; column fetches on its top row.
    always_comb begin
        addr_n = fd_n ? (row_base + ROW_NINE + AW'(wx)) : (row_base + AW'(fx_n));
    end

    // Running wy*IMG_W accumulator and registered linear address.
    always_ff @(posedge clk) begin
        if (!n_rst || start) begin
            row_base   <= '0;
            fetch_addr <= '0;
        end else begin
            fetch_addr <= fv_n ? addr_n : '0;
            if (wy_n != wy) begin
                row_base <= row_base + ROW_STEP;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scan_position_tracker.sv
// Bench for scan_position_tracker on a 16x10 image: a directed vector table
// walking fill, right/down/left scans and a mid-frame restart, followed by
// randomized traffic compared against a behavioural model.
module tb_scan_position_tracker;

    localparam int W  = 16;
    localparam int H  = 10;
    localparam int XW = 5;
    localparam int YW = 4;

    typedef struct packed {
        logic          fv;
        logic          fd;
        logic [XW-1:0] fx;
        logic [YW-1:0] fy;
        logic [3:0]    done;  // {gaussian, gradient, suppression, hysteresis}
        logic [2:0]    flg;   // {readx_up_max, readx_down_min, ready_max}
    } out_t;

    typedef struct {
        logic       start;
        logic [3:0] en;       // {9x9, 7x7, 5x5, 3x3}
        logic [7:0] mode;     // {gaussian, gradient, suppression, hysteresis}
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst, start;
    logic enable9x9, enable7x7, enable5x5, enable3x3;
    logic [1:0] gaussian_buffer, gradient_buffer, suppression_buffer, hysteresis_buffer;
    logic gaussian_fill_done, gradient_fill_done, suppression_fill_done, hysteresis_fill_done;
    logic readx_up_max, readx_down_min, ready_max;
    logic fetch_valid, fetch_dir;
    logic [XW-1:0] fetch_x;
    logic [YW-1:0] fetch_y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scan_position_tracker #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .enable9x9(enable9x9), .enable7x7(enable7x7),
        .enable5x5(enable5x5), .enable3x3(enable3x3),
        .gaussian_buffer(gaussian_buffer), .gradient_buffer(gradient_buffer),
        .suppression_buffer(suppression_buffer), .hysteresis_buffer(hysteresis_buffer),
        .gaussian_fill_done(gaussian_fill_done), .gradient_fill_done(gradient_fill_done),
        .suppression_fill_done(suppression_fill_done), .hysteresis_fill_done(hysteresis_fill_done),
        .readx_up_max(readx_up_max), .readx_down_min(readx_down_min), .ready_max(ready_max),
        .fetch_valid(fetch_valid), .fetch_dir(fetch_dir),
        .fetch_x(fetch_x), .fetch_y(fetch_y)
    );

    function automatic out_t observe();
        out_t o;
        o.fv   = fetch_valid;
        o.fd   = fetch_dir;
        o.fx   = fetch_x;
        o.fy   = fetch_y;
        o.done = {gaussian_fill_done, gradient_fill_done, suppression_fill_done, hysteresis_fill_done};
        o.flg  = {readx_up_max, readx_down_min, ready_max};
        return o;
    endfunction

    // Fetch coordinates only carry meaning when a fetch is expected.
    task automatic check(input string name, input out_t act, input out_t exp);
        out_t a;
        a = act;
        if (!exp.fv) begin
            a.fx = '0;
            a.fy = '0;
        end
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s: got fv=%0b dir=%0b x=%0d y=%0d done=%b flags=%b, expected fv=%0b dir=%0b x=%0d y=%0d done=%b flags=%b",
                     name, a.fv, a.fd, a.fx, a.fy, a.done, a.flg,
                     exp.fv, exp.fd, exp.fx, exp.fy, exp.done, exp.flg);
        end
    endtask

    task automatic drive(input logic rst_in, input logic st, input logic [3:0] en, input logic [7:0] md);
        n_rst              = rst_in;
        start              = st;
        {enable9x9, enable7x7, enable5x5, enable3x3} = en;
        gaussian_buffer    = md[7:6];
        gradient_buffer    = md[5:4];
        suppression_buffer = md[3:2];
        hysteresis_buffer  = md[1:0];
    endtask

    function automatic vec_t mk(logic st, logic [3:0] en, logic [7:0] md, logic fv, logic fd,
                                int fx, int fy, logic [3:0] dn, logic [2:0] fl);
        vec_t v;
        v.start    = st;
        v.en       = en;
        v.mode     = md;
        v.exp.fv   = fv;
        v.exp.fd   = fd;
        v.exp.fx   = fv ? XW'(fx) : '0;
        v.exp.fy   = fv ? YW'(fy) : '0;
        v.exp.done = dn;
        v.exp.flg  = fl;
        return v;
    endfunction

    // Behavioural model: window position, fill phase and per-stage fill progress.
    int  m_wx, m_wy;
    bit  m_fill;
    int  m_cnt[4];
    bit  m_ann[4];
    int  nwin[4] = '{9, 7, 5, 3};

    task automatic model_step(input bit rst_in, input bit st, input logic [3:0] en,
                              input logic [7:0] md, output out_t e);
        int mode[4];
        bit enb[4];
        bit ann_before[4];
        e = '0;
        if (!rst_in || st) begin
            m_wx   = 0;
            m_wy   = 0;
            m_fill = rst_in && st;
            for (int s = 0; s < 4; s++) begin
                m_cnt[s] = 0;
                m_ann[s] = 0;
            end
            return;
        end
        for (int s = 0; s < 4; s++) begin
            mode[s]       = int'(md[7-2*s -: 2]);
            enb[s]        = en[3-s];
            ann_before[s] = m_ann[s];
            if (m_cnt[s] == nwin[s] && !m_ann[s]) begin
                e.done[3-s] = 1'b1;
                m_ann[s]    = 1'b1;
            end
        end
        if (enb[0]) begin
            if (mode[0] == 1) begin
                if (m_fill) begin
                    if (m_cnt[0] < 9) begin
                        e.fv = 1; e.fx = XW'(m_cnt[0]); e.fy = YW'(m_wy);
                    end
                end else if (m_wx < W - 9) begin
                    e.fv = 1; e.fx = XW'(m_wx + 9); e.fy = YW'(m_wy);
                    m_wx++;
                end
            end else if (mode[0] == 2) begin
                if (m_wx > 0) begin
                    e.fv = 1; e.fx = XW'(m_wx - 1); e.fy = YW'(m_wy);
                    m_wx--;
                end
            end else if (mode[0] == 3) begin
                if (m_wy < H - 9) begin
                    e.fv = 1; e.fd = 1; e.fx = XW'(m_wx); e.fy = YW'(m_wy + 9);
                    m_wy++;
                end
            end
        end
        for (int s = 0; s < 4; s++) begin
            if (m_fill && enb[s] && mode[s] == 1 && (s == 0 || ann_before[s-1])
                && m_cnt[s] < nwin[s]) begin
                m_cnt[s]++;
            end
        end
        if (e.done[0]) m_fill = 0;
        if (!m_fill) begin
            e.flg = {m_wx == W - 9, m_wx == 0, m_wy == H - 9};
        end
    endtask

    initial begin
        vec_t vecs[$];
        out_t e;
        logic [3:0] en_r;
        logic [7:0] md_r;
        bit rst_r, st_r;

        // Directed table: fill sequence, right/down/left scan, restart.
        vecs.push_back(mk(1, 4'b0000, 8'h00, 0, 0, 0, 0, 4'b0000, 3'b000));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(0, 4'b1000, 8'h40, 1, 0, i, 0, 4'b0000, 3'b000));
        // Early gradient tick here must be ignored.
        vecs.push_back(mk(0, 4'b1100, 8'h50, 0, 0, 0, 0, 4'b1000, 3'b000));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 4'b0100, 8'h10, 0, 0, 0, 0, 4'b0000, 3'b000));
        vecs.push_back(mk(0, 4'b0000, 8'h00, 0, 0, 0, 0, 4'b0100, 3'b000));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 4'b0010, 8'h04, 0, 0, 0, 0, 4'b0000, 3'b000));
        vecs.push_back(mk(0, 4'b0000, 8'h00, 0, 0, 0, 0, 4'b0010, 3'b000));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 4'b0001, 8'h01, 0, 0, 0, 0, 4'b0000, 3'b000));
        vecs.push_back(mk(0, 4'b0000, 8'h00, 0, 0, 0, 0, 4'b0001, 3'b010));
        vecs.push_back(mk(0, 4'b0000, 8'h00, 0, 0, 0, 0, 4'b0000, 3'b010));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 4'b1000, 8'h40, 1, 0, 9 + i, 0, 4'b0000, (i == 6) ? 3'b100 : 3'b000));
        vecs.push_back(mk(0, 4'b1000, 8'h40, 0, 0, 0, 0, 4'b0000, 3'b100));
        vecs.push_back(mk(0, 4'b1000, 8'hC0, 1, 1, 7, 9, 4'b0000, 3'b101));
        vecs.push_back(mk(0, 4'b1000, 8'hC0, 0, 0, 0, 0, 4'b0000, 3'b101));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 4'b1000, 8'h80, 1, 0, 6 - i, 1, 4'b0000, (i == 6) ? 3'b011 : 3'b001));
        vecs.push_back(mk(0, 4'b1000, 8'h80, 0, 0, 0, 0, 4'b0000, 3'b011));
        vecs.push_back(mk(0, 4'b1000, 8'h40, 1, 0, 9, 1, 4'b0000, 3'b001));
        vecs.push_back(mk(1, 4'b1000, 8'h80, 0, 0, 0, 0, 4'b0000, 3'b000));
        vecs.push_back(mk(0, 4'b1000, 8'h80, 0, 0, 0, 0, 4'b0000, 3'b000));

        drive(0, 0, 4'b0000, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("reset", observe(), out_t'('0));

        foreach (vecs[i]) begin
            drive(1, vecs[i].start, vecs[i].en, vecs[i].mode);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), observe(), vecs[i].exp);
        end

        // Randomized traffic; first cycle resets, second starts a frame.
        for (int c = 0; c < 2000; c++) begin
            rst_r = (c == 0) ? 1'b0 : ($urandom_range(0, 499) != 0);
            st_r  = (c == 1) ? 1'b1 : ($urandom_range(0, 149) == 0);
            for (int b = 0; b < 4; b++) en_r[b] = ($urandom_range(0, 3) != 0);
            md_r = 8'($urandom);
            drive(rst_r, st_r, en_r, md_r);
            @(posedge clk);
            #1;
            model_step(rst_r, st_r, en_r, md_r, e);
            check($sformatf("rand%0d", c), observe(), e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
